// File: rtl/spi_target.sv
// SPI mode-0 target (CPOL=0, CPHA=0, MSB first, 8-bit bytes) with a one-byte
// transmit holding register and a valid/ready receive port, all in the clk_sys_i domain.
module spi_target #(
  parameter logic [7:0] TxIdleByte = 8'hFF
) (
  input  logic       clk_sys_i,
  input  logic       rst_sys_i,
  input  logic       spi_sck_i,
  input  logic       spi_cs_ni,
  input  logic       spi_sdi_i,
  output logic       spi_sdo_o,
  output logic       spi_sdo_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       rx_overflow_o,
  output logic       tx_underrun_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  logic       r_sck_p0, r_sck_p1, r_sck_p2;
  logic       r_cs_p0, r_cs_p1, r_cs_p2;
  logic       r_sdi_p0, r_sdi_p1;
  logic [1:0] r_fill;
  logic       r_armed;
  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx_shift;
  logic [7:0] r_tx_shift;
  logic [7:0] r_hold;
  logic       r_hold_full;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_rx_ovf;
  logic       r_tx_unr;

  logic       w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
  logic       w_shift, w_tx_load, w_rx_done, w_hold_wr;
  logic [7:0] w_rx_byte;

  // A cs_n fall only counts once a genuine high level has been seen after reset,
  // so a cs_n already low at reset release cannot start a frame.
  assign w_sck_rise = r_sck_p1 & ~r_sck_p2;
  assign w_sck_fall = ~r_sck_p1 & r_sck_p2;
  assign w_cs_fall  = r_armed & r_cs_p2 & ~r_cs_p1;
  assign w_cs_rise  = r_cs_p1 & ~r_cs_p2;

  assign w_shift   = (r_state == ST_SHIFT);
  assign w_tx_load = (!w_shift && w_cs_fall) ||
                     (w_shift && !w_cs_rise && w_sck_fall && (r_bit_cnt == 3'd0));
  assign w_rx_done = w_shift && !w_cs_rise && w_sck_rise && (r_bit_cnt == 3'd7);
  assign w_rx_byte = {r_rx_shift, r_sdi_p1};
  assign w_hold_wr = tx_valid_i && !r_hold_full;

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      r_sck_p0    <= 1'b0;
      r_sck_p1    <= 1'b0;
      r_sck_p2    <= 1'b0;
      r_cs_p0     <= 1'b1;
      r_cs_p1     <= 1'b1;
      r_cs_p2     <= 1'b1;
      r_sdi_p0    <= 1'b0;
      r_sdi_p1    <= 1'b0;
      r_fill      <= 2'd0;
      r_armed     <= 1'b0;
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 3'd0;
      r_rx_shift  <= 7'd0;
      r_tx_shift  <= 8'd0;
      r_hold      <= 8'd0;
      r_hold_full <= 1'b0;
      r_rx_data   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_rx_ovf    <= 1'b0;
      r_tx_unr    <= 1'b0;
    end else begin
      // synchroniser stages p0/p1, edge-detect copy p2
      r_sck_p0 <= spi_sck_i;
      r_sck_p1 <= r_sck_p0;
      r_sck_p2 <= r_sck_p1;
      r_cs_p0  <= spi_cs_ni;
      r_cs_p1  <= r_cs_p0;
      r_cs_p2  <= r_cs_p1;
      r_sdi_p0 <= spi_sdi_i;
      r_sdi_p1 <= r_sdi_p0;

      if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
      if (r_fill == 2'd3 && r_cs_p2) r_armed <= 1'b1;

      r_rx_ovf <= 1'b0;
      r_tx_unr <= 1'b0;

      // A write can only land while empty, so a same-cycle load sends TxIdleByte
      // and the freshly written byte stays queued.
      if (w_hold_wr) begin
        r_hold      <= tx_data_i;
        r_hold_full <= 1'b1;
      end else if (w_tx_load && r_hold_full) begin
        r_hold_full <= 1'b0;
      end

      if (w_tx_load) begin
        r_tx_shift <= r_hold_full ? r_hold : TxIdleByte;
        r_tx_unr   <= ~r_hold_full;
      end else if (w_shift && w_cs_rise) begin
        r_tx_shift <= 8'd0;
      end else if (w_shift && w_sck_fall) begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end

      if (w_rx_done) begin
        if (!r_rx_valid || rx_ready_i) begin
          r_rx_data  <= w_rx_byte;
          r_rx_valid <= 1'b1;
        end else begin
          r_rx_ovf <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready_i) begin
        r_rx_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state    <= ST_SHIFT;
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 7'd0;
          end
        end
        ST_SHIFT: begin
          if (w_cs_rise) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 7'd0;
          end else if (w_sck_rise) begin
            r_rx_shift <= w_rx_byte[6:0];
            r_bit_cnt  <= r_bit_cnt + 3'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o        = w_shift;
  assign spi_sdo_oe_o  = w_shift;
  assign spi_sdo_o     = w_shift & r_tx_shift[7];
  assign rx_data_o     = r_rx_data;
  assign rx_valid_o    = r_rx_valid;
  assign tx_ready_o    = ~r_hold_full;
  assign rx_overflow_o = r_rx_ovf;
  assign tx_underrun_o = r_tx_unr;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a behavioural mode-0 controller drives frames,
// a negedge monitor logs accepted bytes and event pulses.
`timescale 1ns/1ps
module tb_spi_target;

  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck, cs_n, sdi;
  logic       sdo, sdo_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic       busy, ovf, unr;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_ovf = 0;
  int n_unr = 0;
  logic [7:0] acc_q [16];
  logic [7:0] mosi_q [4];
  logic [7:0] miso_q [4];

  spi_target #(.TxIdleByte(8'hFF)) dut (
    .clk_sys_i    (clk),
    .rst_sys_i    (rst),
    .spi_sck_i    (sck),
    .spi_cs_ni    (cs_n),
    .spi_sdi_i    (sdi),
    .spi_sdo_o    (sdo),
    .spi_sdo_oe_o (sdo_oe),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (rx_ready),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .busy_o       (busy),
    .rx_overflow_o(ovf),
    .tx_underrun_o(unr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      acc_q[n_acc[3:0]] = rx_data;
      n_acc++;
    end
    if (ovf) n_ovf++;
    if (unr) n_unr++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_hold(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    #1 rx_ready = 1'b1;
    @(negedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
  endtask

  // cs_n rises while sck is still high, so the trailing sck fall lands in IDLE.
  task automatic spi_frame(input int nbytes);
    cs_n = 1'b0;
    #(HALF);
    chk("busy_in_frame", busy, 1);
    chk("oe_in_frame", sdo_oe, 1);
    for (int b = 0; b < nbytes; b++) begin
      for (int i = 7; i >= 0; i--) begin
        sdi = mosi_q[b][i];
        #(HALF);
        miso_q[b][i] = sdo;
        sck = 1'b1;
        #(HALF);
        if (b == nbytes - 1 && i == 0) begin
          cs_n = 1'b1;
          #(HALF);
        end
        sck = 1'b0;
      end
    end
    #(4 * HALF);
  endtask

  task automatic spi_partial(input int nedges);
    cs_n = 1'b0;
    sdi  = 1'b1;
    #(HALF);
    for (int e = 0; e < nedges; e++) begin
      sck = ~sck;
      #(HALF);
    end
    cs_n = 1'b1;
    #(HALF);
    sck = 1'b0;
    #(4 * HALF);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int u0, o0, a0;
    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; sdi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_sdo", sdo, 0);
    chk("rst_oe", sdo_oe, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unr", unr, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // queued 0xA5 out, 0x3C in
    write_hold(8'hA5);
    chk("hold_full", tx_ready, 0);
    u0 = n_unr;
    mosi_q[0] = 8'h3C;
    spi_frame(1);
    chk("t1_sdo_byte", miso_q[0], 8'hA5);
    chk("t1_rx_data", rx_data, 8'h3C);
    chk("t1_rx_valid", rx_valid, 1);
    chk("t1_underruns", n_unr - u0, 0);
    chk("t1_tx_ready", tx_ready, 1);
    chk("t1_busy_after", busy, 0);
    chk("t1_oe_after", sdo_oe, 0);
    chk("t1_sdo_idle", sdo, 0);
    drain();
    chk("t1_valid_cleared", rx_valid, 0);

    // empty holding, 2 bytes, consumer stalled
    u0 = n_unr; o0 = n_ovf;
    mosi_q[0] = 8'h12; mosi_q[1] = 8'h34;
    spi_frame(2);
    chk("t2_sdo_b0", miso_q[0], 8'hFF);
    chk("t2_sdo_b1", miso_q[1], 8'hFF);
    chk("t2_underruns", n_unr - u0, 2);
    chk("t2_rx_data", rx_data, 8'h12);
    chk("t2_rx_valid", rx_valid, 1);
    chk("t2_overflows", n_ovf - o0, 1);
    drain();
    chk("t2_valid_cleared", rx_valid, 0);

    // aborted partial byte, then 0x81
    #1 rx_ready = 1'b1;
    a0 = n_acc; o0 = n_ovf;
    spi_partial(5);
    chk("t3_no_partial", n_acc - a0, 0);
    mosi_q[0] = 8'h81;
    spi_frame(1);
    chk("t3_accepts", n_acc - a0, 1);
    chk("t3_byte", acc_q[a0[3:0]], 8'h81);
    chk("t3_overflows", n_ovf - o0, 0);

    // back-to-back 0x01..0x04
    a0 = n_acc; o0 = n_ovf;
    for (int k = 0; k < 4; k++) mosi_q[k] = 8'(k + 1);
    spi_frame(4);
    chk("t4_accepts", n_acc - a0, 4);
    for (int k = 0; k < 4; k++) chk("t4_byte", acc_q[4'(a0 + k)], 32'(k + 1));
    chk("t4_overflows", n_ovf - o0, 0);

    // reset after 3 bits of a frame
    a0 = n_acc;
    cs_n = 1'b0;
    #(HALF);
    for (int i = 0; i < 3; i++) begin
      sdi = 1'b1; #(HALF); sck = 1'b1; #(HALF); sck = 1'b0;
    end
    write_hold(8'h5A);
    chk("t5_hold_full", tx_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_oe", sdo_oe, 0);
    chk("t5_rst_sdo", sdo, 0);
    chk("t5_rst_rx_data", rx_data, 8'h00);
    chk("t5_rst_rx_valid", rx_valid, 0);
    chk("t5_rst_tx_ready", tx_ready, 1);
    chk("t5_rst_ovf", ovf, 0);
    chk("t5_rst_unr", unr, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sdi = i[0]; #(HALF); sck = 1'b1; #(HALF); sck = 1'b0;
    end
    #(4 * HALF);
    chk("t5_no_rx", n_acc - a0, 0);
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_valid", rx_valid, 0);
    cs_n = 1'b1;
    #(4 * HALF);
    mosi_q[0] = 8'h5A;
    spi_frame(1);
    chk("t5_new_accepts", n_acc - a0, 1);
    chk("t5_new_byte", acc_q[a0[3:0]], 8'h5A);
    chk("t5_new_sdo", miso_q[0], 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 Parameter: TxIdleByte, default 8'hFF, byte shifted out when no transmit data is queued at a byte boundary.
REQ-002 clk_sys_i  input  1  system clock; all state on rising edge.
REQ-003 rst_sys_i  input  1  reset; synchronous, active-high.
REQ-004 spi_sck_i  input  1  SPI clock from controller; asynchronous to clk_sys_i.
REQ-005 spi_cs_ni  input  1  chip select, active-low; asynchronous.
REQ-006 spi_sdi_i  input  1  serial data from controller (controller's spi_tx_o).
REQ-007 spi_sdo_o  output  1  serial data to controller (controller's spi_rx_i).
REQ-008 spi_sdo_oe_o  output  1  output enable for spi_sdo_o; 1 while frame active.
REQ-009 rx_data_o  output  8  last received byte.
REQ-010 rx_valid_o  output  1  rx_data_o holds an unconsumed byte.
REQ-011 rx_ready_i  input  1  consumer accepts rx_data_o when rx_valid_o=1.
REQ-012 tx_data_i  input  8  byte to transmit.
REQ-013 tx_valid_i  input  1  tx_data_i valid.
REQ-014 tx_ready_o  output  1  transmit holding register empty.
REQ-015 busy_o  output  1  frame in progress (state SHIFT).
REQ-016 rx_overflow_o  output  1  one-cycle pulse: received byte dropped.
REQ-017 tx_underrun_o  output  1  one-cycle pulse: TxIdleByte loaded in place of queued data.

Function
REQ-018 SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit bytes; SHALL be the fixed format.
REQ-019 spi_sck_i, spi_cs_ni, spi_sdi_i SHALL each pass a 2-flop synchroniser; edges detected by comparing sync output with one further registered copy.
REQ-020 Correct operation SHALL be guaranteed for clk_sys_i frequency >= 8x spi_sck_i frequency.
REQ-021 State machine SHALL have states IDLE and SHIFT; IDLE->SHIFT on synchronised cs_n falling edge; SHIFT->IDLE on synchronised cs_n rising edge.
REQ-022 On IDLE->SHIFT the tx shift register SHALL load from the holding register if full (holding then empty), else TxIdleByte with tx_underrun_o pulse; bit counter cleared to 0.
REQ-023 spi_sdo_o SHALL equal tx shift register bit 7 in SHIFT and 0 in IDLE; spi_sdo_oe_o = busy_o.
REQ-024 On each synchronised sck rising edge in SHIFT: shift sync sdi into rx shift register LSB, increment 3-bit bit counter (wraps 7->0).
REQ-025 On the rising edge that wraps the counter to 0, the completed byte SHALL be presented on rx_data_o with rx_valid_o=1 the next cycle.
REQ-026 If rx_valid_o=1 and rx_ready_i=0 in the completion cycle, new byte SHALL be dropped, rx_data_o retained, rx_overflow_o pulsed.
REQ-027 If rx_valid_o=1 and rx_ready_i=1 in the completion cycle, new byte SHALL be accepted, rx_valid_o stays 1, no overflow.
REQ-028 rx_valid_o SHALL clear the cycle after rx_valid_o&rx_ready_i with no new byte completing.
REQ-029 On each synchronised sck falling edge in SHIFT: if bit counter = 0, load next tx byte per REQ-022 rule; else shift tx register left by one.
REQ-030 tx_valid_i&tx_ready_o SHALL write tx_data_i into holding register; tx_ready_o = holding empty; a write and a load in the same cycle SHALL leave the written byte in holding.
REQ-031 cs_n deassert mid-byte SHALL discard partial rx bits and tx shift contents, clear counter, no rx_valid_o, holding register untouched.
REQ-032 Edges of sck while in IDLE SHALL be ignored.

Reset
REQ-033 While rst_sys_i=1: state IDLE, synchronisers to idle levels (sck 0, cs_n 1), shift registers/counter 0, holding empty; outputs spi_sdo_o=0, spi_sdo_oe_o=0, rx_data_o=0, rx_valid_o=0, tx_ready_o=1, busy_o=0, rx_overflow_o=0, tx_underrun_o=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame; after release, block waits in IDLE for next cs_n falling edge even if cs_n is low.

Verification
REQ-035 Queue 0xA5, frame sending 0x3C -> sdo bits 1,0,1,0,0,1,0,1; rx_data_o=0x3C, rx_valid_o=1; tx_underrun_o never pulses.
REQ-036 Empty holding, 2-byte frame sending 0x12,0x34 -> sdo 0xFF,0xFF, two tx_underrun_o pulses; with rx_ready_i=0 rx_data_o=0x12, one rx_overflow_o pulse.
REQ-037 cs_n high after 5 sck edges, then full frame sending 0x81 -> only 0x81 reported, one rx_valid_o.
REQ-038 rx_ready_i held 1, back-to-back bytes 0x01..0x04 -> four accepted bytes in order, no overflow.
REQ-039 rst_sys_i pulse after 3 bits of a frame -> all outputs at reset values; further sck edges before a new cs_n fall produce no rx_valid_o.
